// File: rtl/stage_ex_md_pkg.sv
// Shared encodings for the execute stage with the RV32M multiply/divide unit:
// ALU operations, operand sources, branch and md funct3 codes, md FSM states.
`timescale 1ns/1ps
package stage_ex_md_pkg;

    localparam int ALU_SRC_W = 2;

    localparam logic [ALU_SRC_W-1:0] ALU_SRC_REG = 2'd0;
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_PC  = 2'd1;
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM = 2'd2;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;
    localparam logic [3:0] ALU_OP_AND = 4'd2;
    localparam logic [3:0] ALU_OP_XOR = 4'd3;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    localparam logic [2:0] func3_MUL    = 3'd0;
    localparam logic [2:0] func3_MULH   = 3'd1;
    localparam logic [2:0] func3_MULHSU = 3'd2;
    localparam logic [2:0] func3_MULHU  = 3'd3;
    localparam logic [2:0] func3_DIV    = 3'd4;
    localparam logic [2:0] func3_DIVU   = 3'd5;
    localparam logic [2:0] func3_REM    = 3'd6;
    localparam logic [2:0] func3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_STATE_IDLE = 2'd0,
        MD_STATE_RUN  = 2'd1,
        MD_STATE_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative radix-2 RV32M unit: shift-add multiply, restoring divide on magnitudes.
// Build option EX_FAST_MUL_EN: MUL* use a single-cycle combinational multiplier.
`timescale 1ns/1ps
module ex_muldiv_iter
    import stage_ex_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              advance,
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int ITER_W = $clog2(DATA_W + 1);

    md_state_t         state;
    logic [ITER_W-1:0] iter;
    logic [2:0]        func_q;
    logic [DATA_W-1:0] acc_hi, acc_lo, mag_b;
    logic              res_neg, rem_neg;

    logic              div_op, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [DATA_W-1:0] mag_a_in, mag_b_in;
    logic [DATA_W:0]   mul_sum, div_shift;
    logic              div_ge;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0] quo, rem;

    always_comb begin
        div_op   = func[2];
        a_signed = (func == func3_MULH) || (func == func3_MULHSU) ||
                   (func == func3_DIV)  || (func == func3_REM);
        b_signed = (func == func3_MULH) || (func == func3_DIV) || (func == func3_REM);
        a_neg    = a_signed & op_a[DATA_W-1];
        b_neg    = b_signed & op_b[DATA_W-1];
        mag_a_in = a_neg ? -op_a : op_a;
        mag_b_in = b_neg ? -op_b : op_b;
        div_zero = div_op & (op_b == '0);
        div_ovf  = div_op & a_signed & (op_a == {1'b1, {(DATA_W-1){1'b0}}}) & (op_b == '1);
    end

    // acc_hi/acc_lo are product hi/lo for multiply and remainder/quotient for divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(DATA_W+1){1'b0}});
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, mag_b};
        prod      = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo       = res_neg ? -acc_lo : acc_lo;
        rem       = rem_neg ? -acc_hi : acc_hi;
        case (func_q)
            func3_MUL:                              result = prod[DATA_W-1:0];
            func3_MULH, func3_MULHSU, func3_MULHU:  result = prod[2*DATA_W-1:DATA_W];
            func3_DIV, func3_DIVU:                  result = quo;
            default:                                result = rem;
        endcase
    end

    assign busy = (state == MD_STATE_RUN);
    assign done = (state == MD_STATE_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MD_STATE_IDLE;
            iter    <= '0;
            func_q  <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mag_b   <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else begin
            case (state)
                MD_STATE_IDLE: begin
                    if (start) begin
                        func_q  <= func;
                        mag_b   <= mag_b_in;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        acc_hi  <= '0;
                        acc_lo  <= mag_a_in;
                        iter    <= ITER_W'(DATA_W);
                        state   <= MD_STATE_RUN;
                        // special cases store raw results, so sign correction is disabled
                        if (div_zero) begin
                            acc_lo  <= '1;
                            acc_hi  <= op_a;
                            res_neg <= 1'b0;
                            rem_neg <= 1'b0;
                            state   <= MD_STATE_DONE;
                        end else if (div_ovf) begin
                            acc_lo  <= op_a;
                            acc_hi  <= '0;
                            res_neg <= 1'b0;
                            rem_neg <= 1'b0;
                            state   <= MD_STATE_DONE;
                        end
`ifdef EX_FAST_MUL_EN
                        else if (!div_op) begin
                            {acc_hi, acc_lo} <= (2*DATA_W)'(mag_a_in) * (2*DATA_W)'(mag_b_in);
                            state            <= MD_STATE_DONE;
                        end
`endif
                    end
                end
                MD_STATE_RUN: begin
                    if (abort) begin
                        state <= MD_STATE_IDLE;
                    end else begin
                        if (!func_q[2]) begin
                            acc_hi <= mul_sum[DATA_W:1];
                            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                        end else begin
                            acc_hi <= div_ge ? (div_shift[DATA_W-1:0] - mag_b) : div_shift[DATA_W-1:0];
                            acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
                        end
                        iter <= iter - 1'b1;
                        if (iter == ITER_W'(1)) state <= MD_STATE_DONE;
                    end
                end
                MD_STATE_DONE: begin
                    if (abort || advance) state <= MD_STATE_IDLE;
                end
                default: state <= MD_STATE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/stage_ex_md.sv
// Execute stage: forwarding, ALU, branch resolution and EX/MM pipeline register,
// plus the ex_muldiv_iter RV32M unit (build option EX_FAST_MUL_EN speeds up MUL*).
`timescale 1ns/1ps
module stage_ex_md
    import stage_ex_md_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int INST_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] pc,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   reg_wr,
    input  logic                   is_jump,
    input  logic                   is_branch,
    input  logic [REG_ADDR_W-1:0]  reg_addr_rd,
    input  logic [REG_ADDR_W-1:0]  reg_addr_r1,
    input  logic [REG_ADDR_W-1:0]  reg_addr_r2,
    input  logic [3:0]             alu_op,
    input  logic [ALU_SRC_W-1:0]   alu_src_arg1,
    input  logic [ALU_SRC_W-1:0]   alu_src_arg2,
    input  logic [DATA_W-1:0]      imm,
    input  logic [DATA_W-1:0]      reg_data_r1,
    input  logic [DATA_W-1:0]      reg_data_r2,
    input  logic [2:0]             branch_type,
    input  logic                   is_md,
    input  logic [2:0]             md_func,
    input  logic                   ffw_EX_reg_wr,
    input  logic                   ffw_MM_reg_wr,
    input  logic [REG_ADDR_W-1:0]  ffw_EX_reg_addr_rd,
    input  logic [REG_ADDR_W-1:0]  ffw_MM_reg_addr_rd,
    input  logic [DATA_W-1:0]      ffw_EX_reg_data_rd,
    input  logic [DATA_W-1:0]      ffw_MM_reg_data_rd,
    output logic                   stall_req,
    output logic                   jump,
    output logic [DATA_W-1:0]      jump_addr,
    output logic [DATA_W-1:0]      mem_addr,
    output logic                   out_reg_wr,
    output logic                   out_is_load,
    output logic                   out_is_store,
    output logic                   out_flush,
    output logic [REG_ADDR_W-1:0]  out_reg_addr_rd,
    output logic [DATA_W-1:0]      out_reg_data_rd,
    output logic [DATA_W-1:0]      out_alu_mem_addr
);

    logic [DATA_W-1:0] r1_fwd, r2_fwd, arg1, arg2, alu_res, link, md_result, wb_data;
    logic              br_taken, md_busy, md_done, md_start, advance, bubble;

    always_comb begin
        if (ffw_EX_reg_wr && ffw_EX_reg_addr_rd == reg_addr_r1)      r1_fwd = ffw_EX_reg_data_rd;
        else if (ffw_MM_reg_wr && ffw_MM_reg_addr_rd == reg_addr_r1) r1_fwd = ffw_MM_reg_data_rd;
        else                                                          r1_fwd = reg_data_r1;
        if (ffw_EX_reg_wr && ffw_EX_reg_addr_rd == reg_addr_r2)      r2_fwd = ffw_EX_reg_data_rd;
        else if (ffw_MM_reg_wr && ffw_MM_reg_addr_rd == reg_addr_r2) r2_fwd = ffw_MM_reg_data_rd;
        else                                                          r2_fwd = reg_data_r2;
    end

    always_comb begin
        case (alu_src_arg1)
            ALU_SRC_PC:  arg1 = DATA_W'(pc);
            ALU_SRC_IMM: arg1 = imm;
            default:     arg1 = r1_fwd;
        endcase
        case (alu_src_arg2)
            ALU_SRC_PC:  arg2 = DATA_W'(pc);
            ALU_SRC_IMM: arg2 = imm;
            default:     arg2 = r2_fwd;
        endcase
        case (alu_op)
            ALU_OP_SUB: alu_res = arg1 - arg2;
            ALU_OP_AND: alu_res = arg1 & arg2;
            ALU_OP_XOR: alu_res = arg1 ^ arg2;
            default:    alu_res = arg1 + arg2;
        endcase
        case (branch_type)
            BR_BEQ:  br_taken = (r1_fwd == r2_fwd);
            BR_BNE:  br_taken = (r1_fwd != r2_fwd);
            BR_BLT:  br_taken = ($signed(r1_fwd) <  $signed(r2_fwd));
            BR_BGE:  br_taken = ($signed(r1_fwd) >= $signed(r2_fwd));
            BR_BLTU: br_taken = (r1_fwd <  r2_fwd);
            BR_BGEU: br_taken = (r1_fwd >= r2_fwd);
            default: br_taken = 1'b0;
        endcase
        link = DATA_W'(pc) + DATA_W'(32'd4);
    end

    assign jump      = (is_jump | (is_branch & br_taken)) & ~flush;
    assign jump_addr = alu_res;
    assign mem_addr  = alu_res;

    // the md instruction stays at our inputs until the unit reaches DONE
    assign advance   = en & ~stall;
    assign md_start  = ~md_busy & ~md_done & is_md & ~flush & en;
    assign stall_req = md_start | md_busy;
    assign bubble    = flush | (is_md & ~md_done);

    ex_muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start   (md_start),
        .abort   (flush),
        .advance (advance),
        .func    (md_func),
        .op_a    (r1_fwd),
        .op_b    (r2_fwd),
        .busy    (md_busy),
        .done    (md_done),
        .result  (md_result)
    );

    always_comb begin
        if (is_md)         wb_data = md_result;
        else if (is_jump)  wb_data = link;
        else if (is_store) wb_data = r2_fwd;
        else               wb_data = alu_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg_wr       <= 1'b0;
            out_is_load      <= 1'b0;
            out_is_store     <= 1'b0;
            out_flush        <= 1'b1;
            out_reg_addr_rd  <= '0;
            out_reg_data_rd  <= '0;
            out_alu_mem_addr <= '0;
        end else if (advance) begin
            out_reg_wr       <= reg_wr & ~bubble;
            out_is_load      <= is_load & ~bubble;
            out_is_store     <= is_store & ~bubble;
            out_flush        <= bubble;
            out_reg_addr_rd  <= reg_addr_rd;
            out_reg_data_rd  <= wb_data;
            out_alu_mem_addr <= alu_res;
        end
    end

endmodule

// File: tb/tb_stage_ex_md.sv
// Directed self-checking bench for stage_ex_md: ALU, branches, forwarding and RV32M ops.
`timescale 1ns/1ps
module tb_stage_ex_md;
    import stage_ex_md_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, stall, flush;
    logic [31:0] pc;
    logic        is_load, is_store, reg_wr, is_jump, is_branch;
    logic [4:0]  reg_addr_rd, reg_addr_r1, reg_addr_r2;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_arg1, alu_src_arg2;
    logic [31:0] imm, reg_data_r1, reg_data_r2;
    logic [2:0]  branch_type;
    logic        is_md;
    logic [2:0]  md_func;
    logic        ffw_EX_reg_wr, ffw_MM_reg_wr;
    logic [4:0]  ffw_EX_reg_addr_rd, ffw_MM_reg_addr_rd;
    logic [31:0] ffw_EX_reg_data_rd, ffw_MM_reg_data_rd;
    logic        stall_req, jump;
    logic [31:0] jump_addr, mem_addr;
    logic        out_reg_wr, out_is_load, out_is_store, out_flush;
    logic [4:0]  out_reg_addr_rd;
    logic [31:0] out_reg_data_rd, out_alu_mem_addr;

    int checks = 0;
    int errors = 0;

`ifdef EX_FAST_MUL_EN
    localparam int MUL_CYCLES = 1;
`else
    localparam int MUL_CYCLES = 33;
`endif

    stage_ex_md dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush), .pc(pc),
        .is_load(is_load), .is_store(is_store), .reg_wr(reg_wr), .is_jump(is_jump),
        .is_branch(is_branch), .reg_addr_rd(reg_addr_rd), .reg_addr_r1(reg_addr_r1),
        .reg_addr_r2(reg_addr_r2), .alu_op(alu_op), .alu_src_arg1(alu_src_arg1),
        .alu_src_arg2(alu_src_arg2), .imm(imm), .reg_data_r1(reg_data_r1),
        .reg_data_r2(reg_data_r2), .branch_type(branch_type), .is_md(is_md),
        .md_func(md_func), .ffw_EX_reg_wr(ffw_EX_reg_wr), .ffw_MM_reg_wr(ffw_MM_reg_wr),
        .ffw_EX_reg_addr_rd(ffw_EX_reg_addr_rd), .ffw_MM_reg_addr_rd(ffw_MM_reg_addr_rd),
        .ffw_EX_reg_data_rd(ffw_EX_reg_data_rd), .ffw_MM_reg_data_rd(ffw_MM_reg_data_rd),
        .stall_req(stall_req), .jump(jump), .jump_addr(jump_addr), .mem_addr(mem_addr),
        .out_reg_wr(out_reg_wr), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_flush(out_flush), .out_reg_addr_rd(out_reg_addr_rd),
        .out_reg_data_rd(out_reg_data_rd), .out_alu_mem_addr(out_alu_mem_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en = 1'b1; stall = 1'b0; flush = 1'b0; pc = '0;
        is_load = 1'b0; is_store = 1'b0; reg_wr = 1'b0; is_jump = 1'b0; is_branch = 1'b0;
        reg_addr_rd = 5'd0; reg_addr_r1 = 5'd1; reg_addr_r2 = 5'd2;
        alu_op = ALU_OP_ADD; alu_src_arg1 = ALU_SRC_REG; alu_src_arg2 = ALU_SRC_REG;
        imm = '0; reg_data_r1 = '0; reg_data_r2 = '0; branch_type = 3'd2;
        is_md = 1'b0; md_func = '0;
        ffw_EX_reg_wr = 1'b0; ffw_MM_reg_wr = 1'b0;
        ffw_EX_reg_addr_rd = '0; ffw_MM_reg_addr_rd = '0;
        ffw_EX_reg_data_rd = '0; ffw_MM_reg_data_rd = '0;
    endtask

    // Drives one md instruction until writeback; returns stall length and captured result
    task automatic md_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit chg_fwd, output int cycles, output logic [31:0] res,
                         output logic wr, output logic mid_flush);
        is_md = 1'b1; md_func = f; reg_data_r1 = a; reg_data_r2 = b;
        reg_wr = 1'b1; reg_addr_rd = 5'd5;
        cycles = 0; mid_flush = 1'b0;
        #1;
        while (stall_req === 1'b1 && cycles < 200) begin
            cycles++;
            tick();
            if (cycles == 1) begin
                mid_flush = out_flush;
                if (chg_fwd) ffw_EX_reg_data_rd = 32'd99;
            end
        end
        tick();
        res = out_reg_data_rd;
        wr = out_reg_wr;
        is_md = 1'b0; reg_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_flush !== 1'b1) begin errors++; $display("[TB] FAIL reset_flush got %b exp 1", out_flush); end
        checks++; if (out_reg_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_reg_wr got %b exp 0", out_reg_wr); end
        checks++; if (out_is_load !== 1'b0 || out_is_store !== 1'b0) begin errors++; $display("[TB] FAIL reset_ldst got %b%b exp 00", out_is_load, out_is_store); end
        checks++; if (out_reg_data_rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", out_reg_data_rd); end
        checks++; if (out_alu_mem_addr !== 32'h0 || out_reg_addr_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr got %h/%0d exp 0/0", out_alu_mem_addr, out_reg_addr_rd); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_req got %b exp 0", stall_req); end
    endtask

    task automatic test_alu();
        reg_wr = 1'b1; reg_addr_rd = 5'd9; reg_data_r1 = 32'd10; reg_data_r2 = 32'd20;
        tick();
        checks++; if (out_reg_data_rd !== 32'd30 || out_reg_wr !== 1'b1 || out_flush !== 1'b0 || out_reg_addr_rd !== 5'd9)
            begin errors++; $display("[TB] FAIL alu_add got %h wr%b fl%b rd%0d exp 1e wr1 fl0 rd9", out_reg_data_rd, out_reg_wr, out_flush, out_reg_addr_rd); end
        alu_op = ALU_OP_SUB;
        stall = 1'b1;
        tick();
        checks++; if (out_reg_data_rd !== 32'd30) begin errors++; $display("[TB] FAIL stall_hold got %h exp 1e", out_reg_data_rd); end
        stall = 1'b0;
        tick();
        checks++; if (out_reg_data_rd !== 32'hFFFFFFF6) begin errors++; $display("[TB] FAIL alu_sub got %h exp fffffff6", out_reg_data_rd); end
        alu_op = ALU_OP_AND; reg_data_r1 = 32'hF0F0; imm = 32'h0FF0; alu_src_arg2 = ALU_SRC_IMM;
        tick();
        checks++; if (out_reg_data_rd !== 32'h00F0) begin errors++; $display("[TB] FAIL alu_and got %h exp f0", out_reg_data_rd); end
        alu_op = ALU_OP_XOR; reg_data_r1 = 32'hFF00;
        tick();
        checks++; if (out_reg_data_rd !== 32'hF0F0) begin errors++; $display("[TB] FAIL alu_xor got %h exp f0f0", out_reg_data_rd); end
        alu_op = ALU_OP_ADD; reg_wr = 1'b0; is_store = 1'b1; reg_data_r1 = 32'h1000; imm = 32'd8;
        reg_data_r2 = 32'h1111; ffw_EX_reg_wr = 1'b1; ffw_EX_reg_addr_rd = 5'd2; ffw_EX_reg_data_rd = 32'hABCD;
        #1;
        checks++; if (mem_addr !== 32'h1008) begin errors++; $display("[TB] FAIL store_mem_addr got %h exp 1008", mem_addr); end
        tick();
        checks++; if (out_reg_data_rd !== 32'hABCD || out_alu_mem_addr !== 32'h1008 || out_is_store !== 1'b1 || out_reg_wr !== 1'b0)
            begin errors++; $display("[TB] FAIL store_pipe got %h/%h st%b wr%b exp abcd/1008 st1 wr0", out_reg_data_rd, out_alu_mem_addr, out_is_store, out_reg_wr); end
        is_store = 1'b0; ffw_EX_reg_wr = 1'b0; reg_wr = 1'b1; flush = 1'b1;
        tick();
        checks++; if (out_reg_wr !== 1'b0 || out_flush !== 1'b1) begin errors++; $display("[TB] FAIL flush_bubble got wr%b fl%b exp wr0 fl1", out_reg_wr, out_flush); end
        clear_inputs();
    endtask

    task automatic test_branch();
        is_branch = 1'b1; branch_type = BR_BEQ; pc = 32'h100; imm = 32'h20;
        alu_src_arg1 = ALU_SRC_PC; alu_src_arg2 = ALU_SRC_IMM;
        reg_addr_r1 = 5'd7; reg_data_r1 = 32'd0; reg_data_r2 = 32'd5;
        ffw_MM_reg_wr = 1'b1; ffw_MM_reg_addr_rd = 5'd7; ffw_MM_reg_data_rd = 32'd5;
        #1;
        checks++; if (jump !== 1'b1 || jump_addr !== 32'h120) begin errors++; $display("[TB] FAIL beq_taken got j%b %h exp j1 120", jump, jump_addr); end
        flush = 1'b1;
        #1;
        checks++; if (jump !== 1'b0) begin errors++; $display("[TB] FAIL beq_flush got %b exp 0", jump); end
        flush = 1'b0; branch_type = BR_BNE;
        #1;
        checks++; if (jump !== 1'b0) begin errors++; $display("[TB] FAIL bne_not_taken got %b exp 0", jump); end
        branch_type = BR_BEQ; ffw_EX_reg_wr = 1'b1; ffw_EX_reg_addr_rd = 5'd7; ffw_EX_reg_data_rd = 32'd9;
        #1;
        checks++; if (jump !== 1'b0) begin errors++; $display("[TB] FAIL fwd_ex_priority got %b exp 0", jump); end
        branch_type = BR_BLT;
        #1;
        checks++; if (jump !== 1'b0) begin errors++; $display("[TB] FAIL blt_9_5 got %b exp 0", jump); end
        clear_inputs();
        is_jump = 1'b1; reg_wr = 1'b1; pc = 32'h200; imm = 32'h40;
        alu_src_arg1 = ALU_SRC_PC; alu_src_arg2 = ALU_SRC_IMM;
        #1;
        checks++; if (jump !== 1'b1 || jump_addr !== 32'h240) begin errors++; $display("[TB] FAIL jal_target got j%b %h exp j1 240", jump, jump_addr); end
        tick();
        checks++; if (out_reg_data_rd !== 32'h204) begin errors++; $display("[TB] FAIL jal_link got %h exp 204", out_reg_data_rd); end
        clear_inputs();
    endtask

    task automatic test_mul();
        int cyc; logic [31:0] res; logic wr, mf;
        md_op(func3_MUL, 32'd7, 32'hFFFFFFFD, 1'b0, cyc, res, wr, mf);
        checks++; if (cyc != MUL_CYCLES) begin errors++; $display("[TB] FAIL mul_stall_len got %0d exp %0d", cyc, MUL_CYCLES); end
        checks++; if (res !== 32'hFFFFFFEB || wr !== 1'b1) begin errors++; $display("[TB] FAIL mul_result got %h wr%b exp ffffffeb wr1", res, wr); end
        checks++; if (mf !== 1'b1) begin errors++; $display("[TB] FAIL mul_bubble got %b exp 1", mf); end
        md_op(func3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu got %h exp fffffffe", res); end
        md_op(func3_MULH, 32'hFFFFFFFF, 32'd2, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulh got %h exp ffffffff", res); end
        md_op(func3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulhsu got %h exp ffffffff", res); end
        md_op(func3_MULH, 32'h00010000, 32'h00030000, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'h00000003) begin errors++; $display("[TB] FAIL mulh_pos got %h exp 3", res); end
    endtask

    task automatic test_div();
        int cyc; logic [31:0] res; logic wr, mf;
        md_op(func3_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg got %h exp fffffffd", res); end
        checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL div_stall_len got %0d exp 33", cyc); end
        md_op(func3_REM, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL rem_neg got %h exp ffffffff", res); end
        md_op(func3_DIVU, 32'd100, 32'd7, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'd14) begin errors++; $display("[TB] FAIL divu got %h exp e", res); end
        md_op(func3_REMU, 32'd100, 32'd7, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'd2) begin errors++; $display("[TB] FAIL remu got %h exp 2", res); end
    endtask

    task automatic test_div_special();
        int cyc; logic [31:0] res; logic wr, mf;
        md_op(func3_DIVU, 32'd5, 32'd0, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'hFFFFFFFF || cyc != 1) begin errors++; $display("[TB] FAIL divu_zero got %h cyc%0d exp ffffffff cyc1", res, cyc); end
        md_op(func3_REM, 32'd5, 32'd0, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'd5) begin errors++; $display("[TB] FAIL rem_zero got %h exp 5", res); end
        md_op(func3_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'h80000000 || cyc != 1) begin errors++; $display("[TB] FAIL div_ovf got %h cyc%0d exp 80000000 cyc1", res, cyc); end
        md_op(func3_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'h0) begin errors++; $display("[TB] FAIL rem_ovf got %h exp 0", res); end
    endtask

    task automatic test_forward();
        int cyc; logic [31:0] res; logic wr, mf;
        ffw_EX_reg_wr = 1'b1; ffw_EX_reg_addr_rd = 5'd1; ffw_EX_reg_data_rd = 32'd12;
        md_op(func3_MUL, 32'd0, 32'd3, 1'b1, cyc, res, wr, mf);
        checks++; if (res !== 32'd36) begin errors++; $display("[TB] FAIL fwd_latched got %0d exp 36", res); end
        clear_inputs();
    endtask

    task automatic test_abort();
        int cyc; logic [31:0] res; logic wr, mf;
        is_md = 1'b1; md_func = func3_DIVU; reg_data_r1 = 32'd100; reg_data_r2 = 32'd7; reg_wr = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        checks++; if (stall_req !== 1'b0 || out_reg_wr !== 1'b0 || out_flush !== 1'b1)
            begin errors++; $display("[TB] FAIL flush_abort got sr%b wr%b fl%b exp sr0 wr0 fl1", stall_req, out_reg_wr, out_flush); end
        flush = 1'b0; is_md = 1'b0; reg_wr = 1'b0;
        tick();
        md_op(func3_DIVU, 32'd5, 32'd0, 1'b0, cyc, res, wr, mf);
        checks++; if (cyc != 1 || res !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL abort_idle got cyc%0d %h exp cyc1 ffffffff", cyc, res); end
        is_md = 1'b1; md_func = func3_MUL; reg_data_r1 = 32'd7; reg_data_r2 = 32'd3; reg_wr = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1; is_md = 1'b0; reg_wr = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (stall_req !== 1'b0 || out_reg_wr !== 1'b0 || out_flush !== 1'b1 || out_reg_data_rd !== 32'h0 || out_reg_addr_rd !== 5'd0)
            begin errors++; $display("[TB] FAIL rst_mid_run got sr%b wr%b fl%b d%h exp sr0 wr0 fl1 d0", stall_req, out_reg_wr, out_flush, out_reg_data_rd); end
        md_op(func3_MUL, 32'd6, 32'd7, 1'b0, cyc, res, wr, mf);
        checks++; if (res !== 32'd42 || cyc != MUL_CYCLES) begin errors++; $display("[TB] FAIL after_rst got %0d cyc%0d exp 42 cyc%0d", res, cyc, MUL_CYCLES); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_alu();
        test_branch();
        test_mul();
        test_div();
        test_div_special();
        test_forward();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
